// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-bus request logic and IF/ID pipeline register.
// Optional feature: define RV_FETCH_SKIDBUF_EN to keep a word returned during a stall in a one-entry skid buffer.
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    output logic [ADDR_WIDTH-1:0] o_ibus_addr,
    output logic                  o_ibus_rd,
    input  logic [31:0]           i_ibus_rdata,
    input  logic                  i_ibus_ready,
    output logic                  o_IF_hazard,
    output logic [ADDR_WIDTH-1:0] o_IFID_pc,
    output logic [31:0]           o_IFID_inst,
    output logic                  o_IFID_isValid
);

    localparam logic [31:0]           NOP_INST = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] ifid_pc;
    logic [31:0]           ifid_inst;
    logic                  ifid_valid;

    logic                  skid_full;
    logic                  xfer;
    logic                  advance;
    logic                  pc_step_en;

`ifdef RV_FETCH_SKIDBUF_EN
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic [31:0]           skid_inst;
`else
    assign skid_full = 1'b0;
`endif

    // Bus side: the request drops only in reset or while the skid buffer holds a word.
    assign o_ibus_addr = pc;
    assign o_ibus_rd   = ~i_reset & ~skid_full;
    assign o_IF_hazard = o_ibus_rd & ~i_ibus_ready & ~skid_full;

    assign xfer    = o_ibus_rd & i_ibus_ready;
    assign advance = ~i_stall & ~i_redirect;

`ifdef RV_FETCH_SKIDBUF_EN
    // Every completed transfer is kept: either accepted into IF/ID or captured by the skid buffer.
    assign pc_step_en = xfer;
`else
    assign pc_step_en = xfer & ~i_stall;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc <= RESET_ADDR;
        end else if (i_redirect) begin
            pc <= i_redirect_addr;
        end else if (pc_step_en) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ifid_pc    <= RESET_ADDR;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (i_redirect) begin
            ifid_valid <= 1'b0;
        end else if (advance) begin
`ifdef RV_FETCH_SKIDBUF_EN
            if (skid_full) begin
                ifid_pc    <= skid_pc;
                ifid_inst  <= skid_inst;
                ifid_valid <= 1'b1;
            end else
`endif
            if (xfer) begin
                ifid_pc    <= pc;
                ifid_inst  <= i_ibus_rdata;
                ifid_valid <= 1'b1;
            end else begin
                ifid_inst  <= NOP_INST;
                ifid_valid <= 1'b0;
            end
        end
    end

`ifdef RV_FETCH_SKIDBUF_EN
    always_ff @(posedge i_clock) begin
        if (i_reset || i_redirect || !i_stall) begin
            skid_full <= 1'b0;
        end else if (xfer) begin
            skid_full <= 1'b1;
            skid_pc   <= pc;
            skid_inst <= i_ibus_rdata;
        end
    end
`endif

    assign o_IFID_pc      = ifid_pc;
    assign o_IFID_inst    = ifid_inst;
    assign o_IFID_isValid = ifid_valid;

endmodule
